// File: rtl/quant_wr_arb_pkg.sv
// Shared types and helpers for the 4-to-1 quantized write-back arbiter.
// Optional perf counters in the top are enabled with QWA_PERF_CNT_EN.
package quant_wr_arb_pkg;

    localparam int NUM_CH     = 4;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 128;

    typedef logic [1:0] ch_idx_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

    typedef struct packed {
        logic    found;
        ch_idx_t idx;
    } rr_grant_t;

    // First requesting channel at or after ptr, wrapping modulo NUM_CH.
    function automatic rr_grant_t rr_pick(input logic [NUM_CH-1:0] req, input ch_idx_t ptr);
        rr_grant_t g;
        ch_idx_t   cand;
        g.found = 1'b0;
        g.idx   = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = ptr + ch_idx_t'(i);
            if (!g.found && req[cand]) begin
                g.found = 1'b1;
                g.idx   = cand;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/qwa_chan_fifo.sv
// Per-channel synchronous FIFO with extra-MSB pointers for full/empty.
// A push on a full FIFO is accepted when the same cycle also pops it.
module qwa_chan_fifo
    import quant_wr_arb_pkg::*;
#(
    parameter type entry_t = fifo_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wr_ptr_r;
    logic [PTR_W:0] rd_ptr_r;
    entry_t         mem_r [DEPTH];
    logic           push_ok_s;
    logic           pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign dout      = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Read/write pointer advance; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/quant_wr_arbiter_4to1.sv
// Four write-back streams -> per-channel FIFOs -> round-robin -> one registered
// valid/ready SRAM write port. Define QWA_PERF_CNT_EN for the perf counters.
module quant_wr_arbiter_4to1
    import quant_wr_arb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic              wr_en3,
    input  logic [ADDR_W-1:0] wr_addr3,
    input  logic [DATA_W-1:0] wr_data3,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_ready,
    output logic [3:0]        ovf_flag,
    input  logic              ovf_clr,
    output logic              idle,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_stall_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] drop_s;
    entry_t            din_s  [NUM_CH];
    entry_t            dout_s [NUM_CH];

    ch_idx_t           ptr_r;
    rr_grant_t         grant_s;
    logic              load_ok_s;
    logic              mem_wr_en_r;
    logic [ADDR_W-1:0] mem_wr_addr_r;
    logic [DATA_W-1:0] mem_wr_data_r;
    logic [3:0]        ovf_r;
    entry_t            head_s;

    assign push_s   = {wr_en3, wr_en2, wr_en1, wr_en0};
    assign din_s[0] = {wr_addr0, wr_data0};
    assign din_s[1] = {wr_addr1, wr_data1};
    assign din_s[2] = {wr_addr2, wr_data2};
    assign din_s[3] = {wr_addr3, wr_data3};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        qwa_chan_fifo #(
            .entry_t (entry_t),
            .DEPTH   (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_s[g]),
            .pop   (pop_s[g]),
            .din   (din_s[g]),
            .dout  (dout_s[g]),
            .full  (full_s[g]),
            .empty (empty_s[g])
        );
    end

    // A held (unaccepted) output blocks both the grant and the pop.
    assign load_ok_s = !mem_wr_en_r || mem_ready;
    assign grant_s   = rr_pick(~empty_s, ptr_r);
    assign head_s    = dout_s[grant_s.idx];

    // One-hot pop of the granted channel.
    always_comb begin
        pop_s = '0;
        if (load_ok_s && grant_s.found) begin
            pop_s[grant_s.idx] = 1'b1;
        end else begin
            pop_s = '0;
        end
    end

    assign drop_s = push_s & full_s & ~pop_s;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= '0;
            mem_wr_data_r <= '0;
            ptr_r         <= 2'd0;
        end else if (load_ok_s) begin
            if (grant_s.found) begin
                mem_wr_en_r   <= 1'b1;
                mem_wr_addr_r <= head_s.addr;
                mem_wr_data_r <= head_s.data;
                ptr_r         <= grant_s.idx + 2'd1;
            end else begin
                mem_wr_en_r   <= 1'b0;
            end
        end
    end

    // Sticky drop flags; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 4'b0000;
        end else begin
            ovf_r <= (ovf_clr ? 4'b0000 : ovf_r) | drop_s;
        end
    end

    assign mem_wr_en   = mem_wr_en_r;
    assign mem_wr_addr = mem_wr_addr_r;
    assign mem_wr_data = mem_wr_data_r;
    assign ovf_flag    = ovf_r;
    assign idle        = (&empty_s) && !mem_wr_en_r;

`ifdef QWA_PERF_CNT_EN
    logic [31:0] perf_wr_r;
    logic [31:0] perf_stall_r;

    // Saturating count of accepted writes and backpressured cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_wr_r    <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (mem_wr_en_r && mem_ready && (perf_wr_r != 32'hFFFF_FFFF)) begin
                perf_wr_r <= perf_wr_r + 32'd1;
            end
            if (mem_wr_en_r && !mem_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_wr_cnt    = perf_wr_r;
    assign perf_stall_cnt = perf_stall_r;
`else
    assign perf_wr_cnt    = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_quant_wr_arbiter_4to1.sv
// Directed + randomized bench for quant_wr_arbiter_4to1 against a queue-level
// model of the per-channel FIFOs, round-robin grant and output register.
module tb_quant_wr_arbiter_4to1;

    localparam int DW = 128;
    localparam int AW = 16;
    localparam int D  = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    wr_en;
    logic [AW-1:0] wr_addr [4];
    logic [DW-1:0] wr_data [4];
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_ready;
    logic [3:0]    ovf_flag;
    logic          ovf_clr;
    logic          idle;
    logic [31:0]   perf_wr_cnt;
    logic [31:0]   perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    ent_t       mq [4][D];
    int         mcnt [4];
    bit         m_en;
    ent_t       m_out;
    int         m_ptr;
    logic [3:0] m_ovf;
    longint     m_wr;
    longint     m_st;

    always #5 clk = ~clk;

    quant_wr_arbiter_4to1 #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en0(wr_en[0]), .wr_addr0(wr_addr[0]), .wr_data0(wr_data[0]),
        .wr_en1(wr_en[1]), .wr_addr1(wr_addr[1]), .wr_data1(wr_data[1]),
        .wr_en2(wr_en[2]), .wr_addr2(wr_addr[2]), .wr_data2(wr_data[2]),
        .wr_en3(wr_en[3]), .wr_addr3(wr_addr[3]), .wr_data3(wr_data[3]),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_ready(mem_ready), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr), .idle(idle),
        .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the current inputs.
    task automatic model_edge();
        int         g;
        logic [3:0] nov;
        ent_t       e;
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) mcnt[c] = 0;
            m_en = 1'b0; m_out = '0; m_ptr = 0; m_ovf = 4'b0000; m_wr = 0; m_st = 0;
        end else begin
            if (m_en && mem_ready) m_wr++;
            if (m_en && !mem_ready) m_st++;
            g = -1;
            if (!m_en || mem_ready) begin
                for (int i = 0; i < 4; i++)
                    if (g < 0 && mcnt[(m_ptr + i) % 4] > 0) g = (m_ptr + i) % 4;
                if (g >= 0) begin
                    m_out = mq[g][0];
                    for (int j = 0; j < D - 1; j++) mq[g][j] = mq[g][j+1];
                    mcnt[g]--;
                    m_en  = 1'b1;
                    m_ptr = (g + 1) % 4;
                end else begin
                    m_en = 1'b0;
                end
            end
            nov = ovf_clr ? 4'b0000 : m_ovf;
            for (int c = 0; c < 4; c++) begin
                if (wr_en[c]) begin
                    e.a = wr_addr[c];
                    e.d = wr_data[c];
                    if (mcnt[c] < D) begin
                        mq[c][mcnt[c]] = e;
                        mcnt[c]++;
                    end else begin
                        nov[c] = 1'b1;
                    end
                end
            end
            m_ovf = nov;
        end
    endtask

    task automatic check_all();
        bit          m_idle;
        logic [31:0] ew, es;
        m_idle = !m_en && (mcnt[0] == 0) && (mcnt[1] == 0) && (mcnt[2] == 0) && (mcnt[3] == 0);
`ifdef QWA_PERF_CNT_EN
        ew = (m_wr > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_wr[31:0];
        es = (m_st > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_st[31:0];
`else
        ew = 32'd0;
        es = 32'd0;
`endif
        chk("mem_wr_en", mem_wr_en, m_en);
        chk("mem_wr_addr", mem_wr_addr, m_out.a);
        chk("mem_wr_data", mem_wr_data, m_out.d);
        chk("ovf_flag", ovf_flag, m_ovf);
        chk("idle", idle, m_idle);
        chk("perf_wr_cnt", perf_wr_cnt, ew);
        chk("perf_stall_cnt", perf_stall_cnt, es);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic put(input int ch, input logic [AW-1:0] a);
        wr_en[ch]   = 1'b1;
        wr_addr[ch] = a;
        wr_data[ch] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [AW-1:0] ea;
        rst_n = 1'b0; wr_en = 4'b0000; mem_ready = 1'b1; ovf_clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wr_addr[c] = 16'h0000; wr_data[c] = '0; mcnt[c] = 0;
        end
        m_en = 1'b0; m_out = '0; m_ptr = 0; m_ovf = 4'b0000; m_wr = 0; m_st = 0;

        tick(); tick();
        chk("rst_idle", idle, 1'b1);
        chk("rst_en", mem_wr_en, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single write on ch2: visible after the second edge.
        put(2, 16'h0123);
        wr_data[2] = {16{8'hAB}};
        tick(); wr_en = 4'b0000;
        chk("single_lat1", mem_wr_en, 1'b0);
        tick();
        chk("single_en", mem_wr_en, 1'b1);
        chk("single_addr", mem_wr_addr, 16'h0123);
        chk("single_data", mem_wr_data, {16{8'hAB}});
        tick();
        chk("single_idle", idle, 1'b1);

        // One ch3 write moves the RR pointer back to ch0.
        put(3, 16'h0999); tick(); wr_en = 4'b0000; tick(); tick();

        // RR fairness: all channels at once.
        for (int i = 0; i < 4; i++) put(i, 16'h0010 + 16'(i));
        tick(); wr_en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            ea = 16'h0010 + 16'(i);
            chk("rr_addr", mem_wr_addr, ea);
        end
        put(1, 16'h0021); put(0, 16'h0020);
        tick(); wr_en = 4'b0000;
        tick(); chk("rr_ptr0", mem_wr_addr, 16'h0020);
        tick(); chk("rr_next", mem_wr_addr, 16'h0021);
        tick();

        // Backpressure: held output stays stable for 5 cycles.
        put(3, 16'h0300); tick(); wr_en = 4'b0000; tick();
        mem_ready = 1'b0;
        put(3, 16'h0301);
        for (int i = 0; i < 5; i++) begin
            tick(); wr_en = 4'b0000;
            chk("bp_hold_addr", mem_wr_addr, 16'h0300);
            chk("bp_hold_en", mem_wr_en, 1'b1);
        end
        mem_ready = 1'b1;
        tick(); chk("bp_advance", mem_wr_addr, 16'h0301);
        tick(); tick();

        // Overflow on ch1 while the output is stalled.
        mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            put(1, 16'h0100 + 16'(k)); tick();
        end
        wr_en = 4'b0000;
        chk("ovf_set", ovf_flag, 4'b0010);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr", ovf_flag, 4'b0000);
        put(1, 16'h01FF); ovf_clr = 1'b1; tick(); wr_en = 4'b0000; ovf_clr = 1'b0;
        chk("ovf_set_wins", ovf_flag, 4'b0010);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        mem_ready = 1'b1;
        repeat (7) tick();

        // Full FIFO on ch0 accepts a push while being popped.
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(0, 16'h0200 + 16'(k)); tick();
        end
        put(0, 16'h0205); mem_ready = 1'b1;
        tick(); wr_en = 4'b0000;
        chk("full_pop_no_ovf", ovf_flag, 4'b0000);
        chk("full_pop_addr", mem_wr_addr, 16'h0201);
        for (int k = 2; k < 6; k++) begin
            tick();
            ea = 16'h0200 + 16'(k);
            chk("full_pop_order", mem_wr_addr, ea);
        end
        tick();
        chk("full_pop_idle", idle, 1'b1);

        // Mid-operation reset with pending entries and a set flag.
        mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            put(2, 16'h0400 + 16'(k)); tick();
        end
        wr_en = 4'b0000;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mrst_en", mem_wr_en, 1'b0);
        chk("mrst_idle", idle, 1'b1);
        chk("mrst_ovf", ovf_flag, 4'b0000);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst_no_stale", mem_wr_en, 1'b0);
        end

        // Randomized traffic, backpressure, clears and occasional reset.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) begin
                wr_en[c]   = ($urandom_range(0, 2) == 0);
                wr_addr[c] = 16'($urandom);
                wr_data[c] = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        wr_en = 4'b0000; mem_ready = 1'b1; ovf_clr = 1'b0; rst_n = 1'b1;
        repeat (20) tick();
        chk("final_idle", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quant_wr_arbiter_4to1.md
Name: quant_wr_arbiter_4to1

Overview:
Merges the four write-back streams from the 4-channel layer-1 requantize stage into one single-port output feature-map SRAM write port. Each stream (wr_enN/wr_addrN/wr_dataN) enters its own small synchronous FIFO. A round-robin arbiter drains the FIFOs into one registered memory write port that obeys a valid/ready handshake. The block sits between the quant stream block and the output buffer SRAM wrapper.

Parameters:
- DATA_W, 128, write data width (UNIT_NUM*OUT_BITS = 16*8).
- ADDR_W, 16, word address width.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset; synchronous, active-low.
- wr_en0..wr_en3  in  1 each  channel N write strobe.
- wr_addr0..wr_addr3  in  ADDR_W each  channel N word address.
- wr_data0..wr_data3  in  DATA_W each  channel N write data.
- mem_wr_en  out  1  memory write valid.
- mem_wr_addr  out  ADDR_W  memory write address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts the write this cycle.
- ovf_flag  out  4  sticky per-channel overflow (drop) flags.
- ovf_clr  in  1  clears ovf_flag.
- idle  out  1  all FIFOs and output register empty.
- perf_wr_cnt  out  32  accepted memory writes (see Optional Feature).
- perf_stall_cnt  out  32  backpressure cycles (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFOs flushed; mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0; ovf_flag=0; RR pointer=ch0; idle=1; perf counters=0. Reset mid-transfer discards all pending entries and the held output.
- Push: at an edge with wr_enN=1, {addrN,dataN} is written to FIFO N if not full. "Full" accounts for a pop in the same cycle, so push on a full FIFO being popped is accepted.
- Drop: wr_enN=1 on a full FIFO not popped that cycle discards the entry and sets ovf_flag[N]. ovf_flag[N] holds until ovf_clr=1. If set and clear occur in the same cycle, set wins.
- Output register: load_ok = !mem_wr_en || mem_ready.
  - When load_ok is true and any FIFO is non-empty, the arbiter grants one FIFO, pops it, and loads mem_wr_* at the edge (mem_wr_en=1).
  - When load_ok is true and all FIFOs are empty, mem_wr_en goes to 0. Address/data hold their last value.
  - When mem_wr_en=1 and mem_ready=0: mem_wr_en, mem_wr_addr and mem_wr_data are held stable, and no pop occurs.
- Arbitration: round-robin over non-empty FIFOs, starting at ptr. After a grant to channel k, ptr=(k+1) mod 4. ptr changes only on a grant.
- Latency: with mem_ready=1 and the FIFO empty, a write sampled at edge t appears on mem_wr_en during cycle t+1→t+2 (2 edges). Throughput is 1 write/cycle aggregate.
- Ordering: FIFO order is kept per channel. Cross-channel order follows the RR grant sequence only.
- Simultaneous push and pop on one FIFO: both occur and the occupancy count is unchanged.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH)+1 bits, with the MSB used for full/empty disambiguation.
- idle=1 iff all FIFOs are empty and mem_wr_en=0 (combinational from registers).

Optional Feature:
- Macro QWA_PERF_CNT_EN.
- Defined:
  - perf_wr_cnt increments on each mem_wr_en && mem_ready.
  - perf_stall_cnt increments on each mem_wr_en && !mem_ready.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports tied to 0 and no counter logic is synthesized.

Decomposition:
- Package quant_wr_arb_pkg:
  - NUM_CH=4, default ADDR_W/DATA_W;
  - channel index type (2 bits);
  - FIFO entry struct {addr, data}.
- Sub-module qwa_chan_fifo (sync FIFO with push/pop/full/empty/dout), instantiated 4×.
- Arbiter and output register stay in the top module.

Test Plan:
- Single write: wr_en2=1, addr=0x0123, data=all 0xAB, mem_ready=1 → mem_wr_en=1 exactly 2 edges later with addr 0x0123 and data 0xAB..AB; idle returns to 1 the next cycle.
- RR fairness: all four channels write once in the same cycle (addrs 0x10, 0x11, 0x12, 0x13), ptr=0, mem_ready=1 → memory sees 0x10, 0x11, 0x12, 0x13 on consecutive cycles; ptr ends at 0.
- Backpressure: mem_ready=0 for 5 cycles with an entry held → mem_wr_addr/data stable for those cycles and no FIFO pop; perf_stall_cnt=5 when QWA_PERF_CNT_EN is defined; output advances when mem_ready=1.
- Overflow: mem_ready=0 and 5 writes on ch1 with FIFO_DEPTH=4 → the first 4 plus the held output are retained correctly, the 5th is dropped or accepted per load rules, ovf_flag=4'b0010 when a drop occurs; ovf_clr → 0; set and clear in the same cycle → flag stays 1.
- Full with simultaneous pop: ch0 FIFO full, mem_ready=1, new wr_en0 → write accepted, no ovf, and all 5 addresses emerge in order.
- Mid-operation reset: 3 entries pending, rst_n=0 for one edge → mem_wr_en=0, idle=1, ovf_flag=0, and no stale write appears after reset.
